// File: rtl/vdec_viterbi.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2 code (7,5): 4-state ACS with register-exchange survivors.
// Optional channel error estimate port err_cnt when VDEC_ERRCNT_EN is defined.
module vdec_viterbi #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 6
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in,
  output logic        out,
  output logic        out_valid
`ifdef VDEC_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned SUM_W = METRIC_W + 1;
  localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] METRIC_INIT = METRIC_W'(1) << (METRIC_W - 2);
  localparam logic [SUM_W-1:0]    SAT_LIM     = {1'b0, {METRIC_W{1'b1}}};
  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(TB_DEPTH);

  logic                phase_q, phase_d;
  logic                a_q, a_d;
  logic                acs_q, acs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [METRIC_W-1:0] metric_q [4];
  logic [METRIC_W-1:0] metric_d [4];
  logic [TB_DEPTH-1:0] path_q [4];
  logic [TB_DEPTH-1:0] path_d [4];

  logic [SUM_W-1:0]    cand0 [4];
  logic [SUM_W-1:0]    cand1 [4];
  logic [SUM_W-1:0]    nm [4];
  logic [SUM_W-1:0]    diff [4];
  logic                take1 [4];
  logic [TB_DEPTH-1:0] surv [4];
  logic [TB_DEPTH-1:0] path_new [4];
  logic [METRIC_W-1:0] metric_new [4];
  logic [SUM_W-1:0]    m_min;
  logic [1:0]          best;

`ifdef VDEC_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;
`endif

  // Hamming distance between received (a,b) and the code pair leaving state s on input u
  function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic u,
                                               input logic a, input logic b);
    logic g0, g1;
    g0 = u ^ s[0] ^ s[1];
    g1 = u ^ s[1];
    return {1'b0, a ^ g0} + {1'b0, b ^ g1};
  endfunction

  // Add-compare-select for next state {x,u}: predecessors {0,x} and {1,x}, ties to {0,x}
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      cand0[ns] = SUM_W'(metric_q[ns >> 1])
                + SUM_W'(branch_metric(2'(ns >> 1), 1'(ns), a_q, in));
      cand1[ns] = SUM_W'(metric_q[(ns >> 1) + 2])
                + SUM_W'(branch_metric(2'((ns >> 1) + 2), 1'(ns), a_q, in));
      take1[ns] = cand1[ns] < cand0[ns];
      nm[ns]    = take1[ns] ? cand1[ns] : cand0[ns];
      surv[ns]  = take1[ns] ? path_q[(ns >> 1) + 2] : path_q[ns >> 1];
      path_new[ns] = {surv[ns][TB_DEPTH-2:0], 1'(ns)};
    end
    m_min = nm[0];
    for (int ns = 1; ns < 4; ns++) begin
      if (nm[ns] < m_min) m_min = nm[ns];
    end
    for (int ns = 0; ns < 4; ns++) begin
      diff[ns]       = nm[ns] - m_min;
      metric_new[ns] = (diff[ns] > SAT_LIM) ? {METRIC_W{1'b1}} : METRIC_W'(diff[ns]);
    end
  end

  // Lowest-index state holding the zero metric
  always_comb begin
    best = 2'd0;
    for (int ns = 3; ns >= 0; ns--) begin
      if (metric_q[ns] == '0) best = 2'(ns);
    end
  end

`ifdef VDEC_ERRCNT_EN
  assign err_sum = {1'b0, err_cnt_q} + 17'(m_min);
`endif

  always_comb begin
    phase_d     = phase_q;
    a_d         = a_q;
    acs_d       = 1'b0;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    metric_d    = metric_q;
    path_d      = path_q;
`ifdef VDEC_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    if (in_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        a_d = in;
      end else begin
        acs_d    = 1'b1;
        metric_d = metric_new;
        path_d   = path_new;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
`ifdef VDEC_ERRCNT_EN
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
      end
    end
    // One cycle after an ACS step, emit the oldest bit of the best survivor
    if (acs_q) begin
      out_d       = path_q[best][TB_DEPTH-1];
      out_valid_d = (cnt_q == CNT_FULL);
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      phase_q     <= 1'b0;
      a_q         <= 1'b0;
      acs_q       <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      metric_q[0] <= '0;
      for (int i = 1; i < 4; i++) metric_q[i] <= METRIC_INIT;
      for (int i = 0; i < 4; i++) path_q[i] <= '0;
`ifdef VDEC_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      phase_q     <= phase_d;
      a_q         <= a_d;
      acs_q       <= acs_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      metric_q    <= metric_d;
      path_q      <= path_d;
`ifdef VDEC_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`ifdef VDEC_ERRCNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule
